// File: rtl/recomp_shifter.sv
// recomp_shifter: undoes upstream quotient compensation and left-shifts the result; optional saturation via RECOMP_SAT_EN
module recomp_shifter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        led_in,
   input  logic [1:0]  comp_sel,
   input  logic [7:0]  y_in,
   input  logic [3:0]  shift_in,
   output logic        busy,
   output logic        done,
   output logic [23:0] result,
   output logic        ovf
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] COMP  = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   logic [1:0]  state;
   logic        led;
   logic [1:0]  sel;
   logic [7:0]  y;
   logic [3:0]  sh;
   logic [23:0] acc;
   logic [4:0]  cnt;
   logic [8:0]  y_inc;
   logic [8:0]  z;
   logic [4:0]  cnt_c;
   logic [23:0] acc_nx;
   logic [23:0] res_nx;
   logic        ovf_nx;
   logic        to_done;
   // acc_nx is the accumulator value about to be latched; on the DONE transition it is the final result
   always_comb begin
      y_inc   = {1'b0, y} + 9'd1;
      z       = (!led || sel == 2'd0 || sel == 2'd3) ? {1'b0, y} : sel == 2'd1 ? y_inc : y_inc >> 1;
      cnt_c   = (led && sel == 2'd2) ? {1'b0, sh} + 5'd1 : {1'b0, sh};
      acc_nx  = state == COMP ? {15'd0, z} : acc << 1;
      to_done = state == COMP ? cnt_c == 5'd0 : state == SHIFT && cnt == 5'd1;
`ifdef RECOMP_SAT_EN
      ovf_nx  = acc_nx > 24'h00FFFF;
      res_nx  = ovf_nx ? 24'h00FFFF : acc_nx;
`else
      ovf_nx  = 1'b0;
      res_nx  = acc_nx;
`endif
   end
   assign busy = state != IDLE;
   assign done = state == DONE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         led   <= 1'b0;
         sel   <= 2'd0;
         y     <= 8'd0;
         sh    <= 4'd0;
         acc   <= 24'd0;
         cnt   <= 5'd0;
      end else begin
         case (state)
            IDLE: if (start) begin
               led   <= led_in;
               sel   <= comp_sel;
               y     <= y_in;
               sh    <= shift_in;
               state <= COMP;
            end
            COMP: begin
               acc   <= acc_nx;
               cnt   <= cnt_c;
               state <= to_done ? DONE : SHIFT;
            end
            SHIFT: begin
               acc   <= acc_nx;
               cnt   <= cnt - 5'd1;
               state <= to_done ? DONE : SHIFT;
            end
            default: state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) result <= 24'd0;
      else if (to_done) result <= res_nx;
   end
`ifdef RECOMP_SAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf <= 1'b0;
      else if (to_done) ovf <= ovf_nx;
   end
`else
   logic unused_ovf;
   assign unused_ovf = ovf_nx;
   assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_recomp_shifter.sv
// tb_recomp_shifter: directed and randomized checks of recomp_shifter against an arithmetic reference model
module tb_recomp_shifter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        led_in = 1'b0;
   logic [1:0]  comp_sel = 2'd0;
   logic [7:0]  y_in = 8'd0;
   logic [3:0]  shift_in = 4'd0;
   logic        busy;
   logic        done;
   logic        ovf;
   logic [23:0] result;
   int tests = 0;
   int fails = 0;
   recomp_shifter dut (
      .clk(clk), .rst_n(rst_n), .start(start), .led_in(led_in), .comp_sel(comp_sel),
      .y_in(y_in), .shift_in(shift_in), .busy(busy), .done(done), .result(result), .ovf(ovf)
   );
   always #5 clk = ~clk;
   function automatic int m_cnt(input logic l, input logic [1:0] s, input logic [3:0] sh);
      return (l && s == 2'd2) ? int'(sh) + 1 : int'(sh);
   endfunction
   function automatic int m_val(input logic l, input logic [1:0] s, input logic [7:0] y, input logic [3:0] sh);
      int z;
      if (!l || s == 2'd0 || s == 2'd3) z = int'(y);
      else if (s == 2'd1) z = int'(y) + 1;
      else z = (int'(y) + 1) / 2;
      return z * (1 << m_cnt(l, s, sh));
   endfunction
   function automatic int m_res(input int v);
`ifdef RECOMP_SAT_EN
      return v > 65535 ? 65535 : v;
`else
      return v;
`endif
   endfunction
   function automatic int m_ovf(input int v);
`ifdef RECOMP_SAT_EN
      return v > 65535 ? 1 : 0;
`else
      return (v < 0) ? 1 : 0;
`endif
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // one request; latency is counted in edges after the sampling edge (cnt+1, i.e. cnt+2 inclusive)
   task automatic run_op(input logic l, input logic [1:0] s, input logic [7:0] y, input logic [3:0] sh, input string tag);
      int n;
      logic seen;
      int v;
      v = m_val(l, s, y, sh);
      @(negedge clk);
      led_in = l; comp_sel = s; y_in = y; shift_in = sh; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      led_in = 1'($urandom); comp_sel = 2'($urandom); y_in = 8'($urandom); shift_in = 4'($urandom);
      chk({tag, " busy"}, busy, 1);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 25) begin
         @(posedge clk);
         #1;
         n++;
         seen = done;
      end
      chk({tag, " latency"}, n, m_cnt(l, s, sh) + 1);
      chk({tag, " result"}, result, m_res(v));
      chk({tag, " ovf"}, ovf, m_ovf(v));
      @(posedge clk);
      #1;
      chk({tag, " done width"}, done, 0);
      chk({tag, " idle"}, busy, 0);
   endtask
   initial begin
      int nd;
      int first_e;
      int last;
      #1;
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst result", result, 0);
      chk("rst ovf", ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1'b0, 2'd0, 8'h05, 4'd4, "plain");
      // abort mid-shift
      @(negedge clk);
      led_in = 1'b0; comp_sel = 2'd0; y_in = 8'h10; shift_in = 4'd8; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort busy", busy, 0);
      chk("abort result", result, 0);
      chk("abort done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      repeat (20) begin
         @(posedge clk);
         #1 if (done) nd++;
      end
      chk("abort no done", nd, 0);
      run_op(1'b1, 2'd1, 8'hFF, 4'd15, "max");
      run_op(1'b1, 2'd2, 8'h09, 4'd3, "dbl");
      run_op(1'b1, 2'd2, 8'hFF, 4'd15, "dbl max");
      run_op(1'b1, 2'd3, 8'h33, 4'd2, "sel3");
      // start held through COMP and DONE must not queue a second operation
      @(negedge clk);
      led_in = 1'b1; comp_sel = 2'd1; y_in = 8'h00; shift_in = 4'd0; start = 1'b1;
      @(posedge clk);
      nd = 0;
      first_e = 0;
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk);
         #1;
         if (done) begin
            nd++;
            if (first_e == 0) first_e = e;
         end
         if (e == 2) start = 1'b0;
      end
      chk("busy-ignore dones", nd, 1);
      chk("busy-ignore latency", first_e, 1);
      chk("busy-ignore result", result, 1);
      // continuous start: period cnt+3
      @(negedge clk);
      led_in = 1'b0; comp_sel = 2'd0; y_in = 8'h01; shift_in = 4'd1; start = 1'b1;
      @(posedge clk);
      nd = 0;
      last = 0;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk);
         #1;
         if (done) begin
            nd++;
            chk("b2b gap", e - last, nd == 1 ? 2 : 4);
            chk("b2b result", result, 2);
            last = e;
         end
      end
      start = 1'b0;
      chk("b2b count", nd, 5);
      repeat (6) @(posedge clk);
      for (int i = 0; i < 40; i++)
         run_op(1'($urandom), 2'($urandom), 8'($urandom), 4'($urandom), "rnd");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
